cache_set_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_set_ctrl_lru_next.sv | 27 ++
 rtl/cache_set_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cache_set_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache set controller: way index, FSM states,
// pairwise-LRU MRU masks and size defaults.
package cache_pkg;

  localparam int SETS_DEF  = 16;
  localparam int TAG_W_DEF = 8;

  typedef logic [1:0] way_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT,
    ST_FILL,
    ST_RESP
  } state_t;

  // Pair bits: b5=0v1, b4=0v2, b3=0v3, b2=1v2, b1=1v3, b0=2v3 (1 = lower way newer)
  localparam logic [5:0] MRU_SET_W0 = 6'b111000;
  localparam logic [5:0] MRU_CLR_W0 = 6'b000000;
  localparam logic [5:0] MRU_SET_W1 = 6'b000110;
  localparam logic [5:0] MRU_CLR_W1 = 6'b100000;
  localparam logic [5:0] MRU_SET_W2 = 6'b000001;
  localparam logic [5:0] MRU_CLR_W2 = 6'b010100;
  localparam logic [5:0] MRU_SET_W3 = 6'b000000;
  localparam logic [5:0] MRU_CLR_W3 = 6'b001011;

  function automatic logic [5:0] mru_update(input logic [5:0] lru, input way_t way);
    logic [5:0] res;
    case (way)
      2'd0:    res = (lru & ~MRU_CLR_W0) | MRU_SET_W0;
      2'd1:    res = (lru & ~MRU_CLR_W1) | MRU_SET_W1;
      2'd2:    res = (lru & ~MRU_CLR_W2) | MRU_SET_W2;
      default: res = (lru & ~MRU_CLR_W3) | MRU_SET_W3;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cache_set_ctrl_lru_next.sv
// Combinational pairwise-LRU helper: decodes the least-recently-used way and
// computes the LRU state after touching a given way.
module lru_next
  import cache_pkg::*;
(
  input  logic [5:0] lru,
  input  way_t       touch_way,
  output way_t       victim_way,
  output logic [5:0] lru_upd
);

  // Reachable states always encode a total order, so exactly one term matches.
  always_comb begin
    victim_way = 2'd0;
    if (lru[5:3] == 3'b000)
      victim_way = 2'd0;
    else if (lru[5] && (lru[2:1] == 2'b00))
      victim_way = 2'd1;
    else if (lru[4] && lru[2] && !lru[0])
      victim_way = 2'd2;
    else if (lru[3] && lru[1] && lru[0])
      victim_way = 2'd3;
  end

  assign lru_upd = mru_update(lru, touch_way);

endmodule

// File: rtl/cache_set_ctrl.sv
// Tag/valid/dirty/LRU store and single-access lookup controller for a 4-way cache.
// Optional CACHE_STATS_EN adds saturating HitCount/MissCount outputs.
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_LOOKUP | compare latched tag against the set, pick hit way or victim
// ST_EVICT  | dirty victim writeback, waiting for EvictAck
// ST_FILL   | line fetch, waiting for FillAck; install on ack
// ST_RESP   | one-cycle completion pulse
module cache_set_ctrl
  import cache_pkg::*;
#(
  parameter int SETS  = SETS_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic [$clog2(SETS)-1:0]  ReqIndex,
  input  logic [TAG_W-1:0]         ReqTag,
  output logic                     EvictValid,
  output logic [TAG_W-1:0]         EvictTag,
  input  logic                     EvictAck,
  output logic                     FillValid,
  input  logic                     FillAck,
  output logic                     RespValid,
  output logic                     RespHit,
  output logic [1:0]               RespWay
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]              HitCount,
  output logic [15:0]              MissCount
`endif
);

  localparam int IDX_W = $clog2(SETS);

  state_t state, state_nxt;

  logic [TAG_W-1:0] tag_arr   [SETS][4];
  logic [3:0]       valid_arr [SETS];
  logic [3:0]       dirty_arr [SETS];
  logic [5:0]       lru_arr   [SETS];

  logic             lat_write;
  logic [IDX_W-1:0] lat_index;
  logic [TAG_W-1:0] lat_tag;
  way_t             victim_q;
  logic             resp_hit_q;
  way_t             resp_way_q;
  logic [TAG_W-1:0] evict_tag_q;

  logic [3:0] hit_vec;
  logic       any_hit;
  way_t       hit_way;
  logic       any_inv;
  way_t       inv_way;
  way_t       lru_victim;
  way_t       miss_victim;
  way_t       touch_way;
  logic [5:0] lru_upd;
  logic       need_evict;

  always_comb begin
    hit_vec = '0;
    any_hit = 1'b0;
    hit_way = 2'd0;
    any_inv = 1'b0;
    inv_way = 2'd0;
    for (int w = 0; w < 4; w++)
      hit_vec[w] = valid_arr[lat_index][w] && (tag_arr[lat_index][w] == lat_tag);
    for (int w = 3; w >= 0; w--) begin
      if (hit_vec[w]) begin
        any_hit = 1'b1;
        hit_way = way_t'(w);
      end
      if (!valid_arr[lat_index][w]) begin
        any_inv = 1'b1;
        inv_way = way_t'(w);
      end
    end
  end

  assign miss_victim = any_inv ? inv_way : lru_victim;
  assign need_evict  = valid_arr[lat_index][miss_victim] && dirty_arr[lat_index][miss_victim];
  assign touch_way   = (state == ST_FILL) ? victim_q : hit_way;

  lru_next u_lru_next (
    .lru        (lru_arr[lat_index]),
    .touch_way  (touch_way),
    .victim_way (lru_victim),
    .lru_upd    (lru_upd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ReqValid) state_nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (any_hit)         state_nxt = ST_RESP;
        else if (need_evict) state_nxt = ST_EVICT;
        else                 state_nxt = ST_FILL;
      end
      ST_EVICT:  if (EvictAck) state_nxt = ST_FILL;
      ST_FILL:   if (FillAck)  state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write   <= 1'b0;
      lat_index   <= '0;
      lat_tag     <= '0;
      victim_q    <= 2'd0;
      resp_hit_q  <= 1'b0;
      resp_way_q  <= 2'd0;
      evict_tag_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        valid_arr[i] <= '0;
        dirty_arr[i] <= '0;
        lru_arr[i]   <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (ReqValid) begin
            lat_write <= ReqWrite;
            lat_index <= ReqIndex;
            lat_tag   <= ReqTag;
          end
        end
        ST_LOOKUP: begin
          if (any_hit) begin
            lru_arr[lat_index] <= lru_upd;
            if (lat_write) dirty_arr[lat_index][hit_way] <= 1'b1;
            resp_hit_q <= 1'b1;
            resp_way_q <= hit_way;
          end else begin
            victim_q    <= miss_victim;
            evict_tag_q <= tag_arr[lat_index][miss_victim];
          end
        end
        ST_FILL: begin
          if (FillAck) begin
            valid_arr[lat_index][victim_q] <= 1'b1;
            dirty_arr[lat_index][victim_q] <= lat_write;
            lru_arr[lat_index]             <= lru_upd;
            resp_hit_q                     <= 1'b0;
            resp_way_q                     <= victim_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset: they are qualified by valid everywhere.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_FILL) && FillAck)
      tag_arr[lat_index][victim_q] <= lat_tag;
  end

  assign ReqReady   = (state == ST_IDLE);
  assign EvictValid = (state == ST_EVICT);
  assign FillValid  = (state == ST_FILL);
  assign RespValid  = (state == ST_RESP);
  assign RespHit    = resp_hit_q;
  assign RespWay    = resp_way_q;
  assign EvictTag   = evict_tag_q;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else if (state == ST_RESP) begin
      if (resp_hit_q && (HitCount != 16'hFFFF))
        HitCount <= HitCount + 16'd1;
      if (!resp_hit_q && (MissCount != 16'hFFFF))
        MissCount <= MissCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Self-checking bench for cache_set_ctrl: directed scenarios plus randomized
// accesses against a rank-ordered LRU reference model.
module tb_cache_set_ctrl;

  localparam int SETS  = 16;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             ReqValid, ReqReady, ReqWrite;
  logic [3:0]       ReqIndex;
  logic [TAG_W-1:0] ReqTag;
  logic             EvictValid, EvictAck;
  logic [TAG_W-1:0] EvictTag;
  logic             FillValid, FillAck;
  logic             RespValid, RespHit;
  logic [1:0]       RespWay;
`ifdef CACHE_STATS_EN
  logic [15:0]      HitCount, MissCount;
`endif

  cache_set_ctrl #(.SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
    .ReqIndex   (ReqIndex),
    .ReqTag     (ReqTag),
    .EvictValid (EvictValid),
    .EvictTag   (EvictTag),
    .EvictAck   (EvictAck),
    .FillValid  (FillValid),
    .FillAck    (FillAck),
    .RespValid  (RespValid),
    .RespHit    (RespHit),
    .RespWay    (RespWay)
`ifdef CACHE_STATS_EN
    ,
    .HitCount   (HitCount),
    .MissCount  (MissCount)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: rank 0 = most recently used, rank 3 = least recently used.
  logic [TAG_W-1:0] m_tag   [SETS][4];
  bit               m_valid [SETS][4];
  bit               m_dirty [SETS][4];
  int               m_rank  [SETS][4];
  int               m_hits, m_misses;

  int               last_way;
  logic [TAG_W-1:0] last_evict_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_rank[s][w]  = 3 - w;
      end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_touch(input int s, input int w);
    for (int k = 0; k < 4; k++)
      if (m_rank[s][k] < m_rank[s][w]) m_rank[s][k]++;
    m_rank[s][w] = 0;
  endtask

  function automatic logic [5:0] model_lru_bits(input int s);
    logic [5:0] b;
    b[5] = m_rank[s][0] < m_rank[s][1];
    b[4] = m_rank[s][0] < m_rank[s][2];
    b[3] = m_rank[s][0] < m_rank[s][3];
    b[2] = m_rank[s][1] < m_rank[s][2];
    b[1] = m_rank[s][1] < m_rank[s][3];
    b[0] = m_rank[s][2] < m_rank[s][3];
    return b;
  endfunction

  function automatic logic [3:0] model_valid_bits(input int s);
    logic [3:0] v;
    for (int w = 0; w < 4; w++) v[w] = m_valid[s][w];
    return v;
  endfunction

  task automatic do_access(input bit wr, input int idx, input logic [TAG_W-1:0] tag,
                           input int ev_wait, input int fl_wait, input bit abort);
    int  hw, v;
    bit  hit, evict;
    hit = 0; hw = 0;
    for (int w = 0; w < 4; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) begin hit = 1; hw = w; end
    v = -1;
    for (int w = 3; w >= 0; w--) if (!m_valid[idx][w]) v = w;
    if (v < 0)
      for (int w = 0; w < 4; w++) if (m_rank[idx][w] == 3) v = w;
    evict = !hit && m_valid[idx][v] && m_dirty[idx][v];

    check("req_ready_idle", {31'd0, ReqReady}, 32'd1);
    ReqValid = 1; ReqWrite = wr; ReqIndex = idx[3:0]; ReqTag = tag;
    step();
    ReqValid = 0; ReqWrite = ~wr; ReqIndex = 4'($urandom); ReqTag = 8'($urandom);
    EvictAck = 1'($urandom); FillAck = 1'($urandom);
    check("lookup_outs", {28'd0, ReqReady, EvictValid, FillValid, RespValid}, 32'd0);
    step();
    EvictAck = 0; FillAck = 0;

    if (hit) begin
      model_touch(idx, hw);
      if (wr) m_dirty[idx][hw] = 1;
      m_hits++;
      check("hit_resp_n2", {31'd0, RespValid}, 32'd1);
      check("hit_resphit", {31'd0, RespHit}, 32'd1);
      check("hit_respway", {30'd0, RespWay}, hw);
      last_way = hw;
    end else begin
      if (evict) begin
        for (int k = 0; k <= ev_wait; k++) begin
          check("evict_valid", {30'd0, EvictValid, FillValid}, 32'd2);
          check("evict_tag", {24'd0, EvictTag}, {24'd0, m_tag[idx][v]});
          last_evict_tag = EvictTag;
          EvictAck = (k == ev_wait);
          FillAck  = 1'($urandom);
          step();
        end
        EvictAck = 0; FillAck = 0;
      end
      for (int k = 0; k <= fl_wait; k++) begin
        check("fill_valid", {30'd0, EvictValid, FillValid}, 32'd1);
        EvictAck = 1'($urandom);
        if (abort && k == fl_wait) begin
          reset = 1; FillAck = 1;
          step();
          reset = 0; FillAck = 0; EvictAck = 0;
          model_reset();
          check("abort_no_resp", {31'd0, RespValid}, 32'd0);
          check("abort_ready", {31'd0, ReqReady}, 32'd1);
          check("abort_lru", {26'd0, dut.lru_arr[idx]}, 32'd0);
          check("abort_valid", {28'd0, dut.valid_arr[idx]}, 32'd0);
          return;
        end
        FillAck = (k == fl_wait);
        step();
      end
      FillAck = 0; EvictAck = 0;
      m_tag[idx][v]   = tag;
      m_valid[idx][v] = 1;
      m_dirty[idx][v] = wr;
      model_touch(idx, v);
      m_misses++;
      check("miss_resp", {31'd0, RespValid}, 32'd1);
      check("miss_resphit", {31'd0, RespHit}, 32'd0);
      check("miss_respway", {30'd0, RespWay}, v);
      last_way = v;
    end
    step();
    check("resp_one_cycle", {30'd0, RespValid, ReqReady}, 32'd1);
    check("set_lru", {26'd0, dut.lru_arr[idx]}, {26'd0, model_lru_bits(idx)});
    check("set_valid", {28'd0, dut.valid_arr[idx]}, {28'd0, model_valid_bits(idx)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; ReqValid = 0; ReqWrite = 0; ReqIndex = 0; ReqTag = 0;
    EvictAck = 0; FillAck = 0;
    last_way = 0; last_evict_tag = 0;
    model_reset();
    repeat (2) step();
    reset = 0;
    check("rst_ready", {31'd0, ReqReady}, 32'd1);
    check("rst_valids", {29'd0, EvictValid, FillValid, RespValid}, 32'd0);
    check("rst_resp", {29'd0, RespHit, RespWay}, 32'd0);
    check("rst_evict_tag", {24'd0, EvictTag}, 32'd0);

    do_access(0, 3, 8'h11, 0, 0, 0);
    check("plan_first_way", last_way, 0);
    check("plan_lru_111000", {26'd0, dut.lru_arr[3]}, 32'b111000);
    do_access(0, 3, 8'h12, 0, 1, 0);
    do_access(0, 3, 8'h13, 0, 0, 0);
    do_access(0, 3, 8'h14, 0, 2, 0);
    check("plan_lru_000000", {26'd0, dut.lru_arr[3]}, 32'd0);
    do_access(0, 3, 8'h11, 0, 0, 0);
    check("plan_hit_way0", last_way, 0);
    do_access(1, 3, 8'h12, 0, 0, 0);
    do_access(0, 3, 8'h15, 0, 0, 0);
    check("plan_victim_way2", last_way, 2);
    do_access(1, 3, 8'h11, 0, 0, 0);
    do_access(0, 3, 8'h12, 0, 0, 0);
    do_access(0, 3, 8'h15, 0, 0, 0);
    do_access(0, 3, 8'h14, 0, 0, 0);
    do_access(0, 3, 8'h16, 3, 0, 0);
    check("plan_evict_tag", {24'd0, last_evict_tag}, 32'h11);
    check("plan_evict_way0", last_way, 0);
    do_access(0, 5, 8'h20, 0, 1, 1);

    for (int i = 0; i < 250; i++) begin
      int idx;
      idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 2);
      do_access(1'($urandom), idx, 8'(8'h30 + $urandom_range(0, 5)),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 59) == 0);
    end

`ifdef CACHE_STATS_EN
    check("stat_hits", {16'd0, HitCount}, (m_hits > 65535) ? 65535 : m_hits);
    check("stat_misses", {16'd0, MissCount}, (m_misses > 65535) ? 65535 : m_misses);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
